// File: rtl/result_overlay_pkg.sv
// Shared types and default constants for the result overlay banner.
package result_overlay_pkg;

    localparam int DEF_N_SRC         = 3;
    localparam int DEF_RGB_W         = 24;
    localparam int DEF_BLINK_PERIOD  = 15;
    localparam int DEF_BLINK_TOGGLES = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLINK  = 2'd1,
        ST_STEADY = 2'd2
    } ovl_state_e;

    // Bits needed to count 0..n_vals-1, never less than one.
    function automatic int cnt_width(input int n_vals);
        return (n_vals > 1) ? $clog2(n_vals) : 1;
    endfunction

endpackage

// File: rtl/frame_blink_timer.sv
// Frame-based blink timing: frame counter, toggle counter, phase and a
// done strobe on the frame that completes the final toggle.
module frame_blink_timer
    import result_overlay_pkg::*;
#(
    parameter int BLINK_PERIOD  = DEF_BLINK_PERIOD,
    parameter int BLINK_TOGGLES = DEF_BLINK_TOGGLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic start_i,
    input  logic run_i,
    input  logic tick_i,
    output logic phase_o,
    output logic done_o
);

    localparam int FC_W = cnt_width(BLINK_PERIOD);
    localparam int TC_W = cnt_width(BLINK_TOGGLES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_PERIOD - 1);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'((BLINK_TOGGLES > 0) ? BLINK_TOGGLES - 1 : 0);

    logic [FC_W-1:0] frame_cnt_q;
    logic [FC_W-1:0] frame_cnt_d;
    logic [TC_W-1:0] toggle_cnt_q;
    logic [TC_W-1:0] toggle_cnt_d;
    logic            phase_q;
    logic            phase_d;
    logic            period_end_s;
    logic            done_s;

    // Next-state for counters and phase; clear beats start beats counting.
    always_comb begin
        period_end_s = run_i && tick_i && (frame_cnt_q == FC_LAST);
        done_s       = period_end_s && (BLINK_TOGGLES != 0) && (toggle_cnt_q == TC_LAST);
        frame_cnt_d  = frame_cnt_q;
        toggle_cnt_d = toggle_cnt_q;
        phase_d      = phase_q;
        if (clear_i) begin
            frame_cnt_d  = {FC_W{1'b0}};
            toggle_cnt_d = {TC_W{1'b0}};
            phase_d      = 1'b0;
        end else if (start_i) begin
            frame_cnt_d  = {FC_W{1'b0}};
            toggle_cnt_d = {TC_W{1'b0}};
            phase_d      = 1'b1;
        end else if (period_end_s) begin
            frame_cnt_d  = {FC_W{1'b0}};
            toggle_cnt_d = toggle_cnt_q + TC_W'(1);
            // The last toggle lands on steady display, so phase is forced on.
            phase_d      = done_s ? 1'b1 : ~phase_q;
        end else if (run_i && tick_i) begin
            frame_cnt_d  = frame_cnt_q + FC_W'(1);
        end else begin
            frame_cnt_d  = frame_cnt_q;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q  <= {FC_W{1'b0}};
            toggle_cnt_q <= {TC_W{1'b0}};
            phase_q      <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            toggle_cnt_q <= toggle_cnt_d;
            phase_q      <= phase_d;
        end
    end

    assign phase_o = phase_q;
    assign done_o  = done_s;

endmodule

// File: rtl/result_overlay_mux.sv
// Game-result banner overlay: latches the winning/draw sprite source on a
// frame tick, blinks it for a number of frames, then holds it until cleared.
module result_overlay_mux
    import result_overlay_pkg::*;
#(
    parameter int N_SRC         = DEF_N_SRC,
    parameter int RGB_W         = DEF_RGB_W,
    parameter int BLINK_PERIOD  = DEF_BLINK_PERIOD,
    parameter int BLINK_TOGGLES = DEF_BLINK_TOGGLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_tick,
    input  logic                      gano,
    input  logic                      empate,
    input  logic [$clog2(N_SRC)-1:0]  ganador,
    input  logic                      clear,
    input  logic [N_SRC-1:0]          src_visible,
    input  logic [N_SRC*RGB_W-1:0]    src_rgb,
    output logic                      visible,
    output logic [RGB_W-1:0]          rgb,
    output logic                      active
);

    localparam int GW = $clog2(N_SRC);

    ovl_state_e       state_q;
    ovl_state_e       state_d;
    logic [GW-1:0]    sel_q;
    logic [GW-1:0]    sel_d;
    logic             visible_q;
    logic             visible_d;
    logic [RGB_W-1:0] rgb_q;
    logic [RGB_W-1:0] rgb_d;

    logic             result_valid_s;
    logic [GW-1:0]    result_sel_s;
    logic             vis_sel_s;
    logic [RGB_W-1:0] rgb_sel_s;
    logic             phase_s;
    logic             done_s;
    logic             start_s;
    logic             run_s;

    // Decode the game inputs into a source index; a draw outranks a winner.
    always_comb begin
        if (empate) begin
            result_valid_s = 1'b1;
            result_sel_s   = GW'(N_SRC - 1);
        end else if (gano && (ganador != {GW{1'b0}}) && (ganador <= GW'(N_SRC - 1))) begin
            result_valid_s = 1'b1;
            result_sel_s   = ganador - GW'(1);
        end else begin
            result_valid_s = 1'b0;
            result_sel_s   = {GW{1'b0}};
        end
    end

    // One-hot AND-OR pick of the latched source's flag and colour.
    always_comb begin
        vis_sel_s = 1'b0;
        rgb_sel_s = {RGB_W{1'b0}};
        for (int i = 0; i < N_SRC; i++) begin
            vis_sel_s = vis_sel_s | ((sel_q == GW'(i)) & src_visible[i]);
            rgb_sel_s = rgb_sel_s | ({RGB_W{sel_q == GW'(i)}} & src_rgb[i*RGB_W +: RGB_W]);
        end
    end

    assign start_s = (state_q == ST_IDLE) && frame_tick && result_valid_s && !clear;
    assign run_s   = (state_q == ST_BLINK);

    frame_blink_timer #(
        .BLINK_PERIOD  (BLINK_PERIOD),
        .BLINK_TOGGLES (BLINK_TOGGLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear),
        .start_i (start_s),
        .run_i   (run_s),
        .tick_i  (frame_tick),
        .phase_o (phase_s),
        .done_o  (done_s)
    );

    // Banner FSM next-state; the source index only changes when leaving IDLE.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_d = (BLINK_TOGGLES == 0) ? ST_STEADY : ST_BLINK;
                        sel_d   = result_sel_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BLINK: begin
                    if (done_s) begin
                        state_d = ST_STEADY;
                    end else begin
                        state_d = ST_BLINK;
                    end
                end
                ST_STEADY: state_d = ST_STEADY;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Pixel output terms, registered one clock after the current state.
    always_comb begin
        visible_d = (state_q != ST_IDLE) && phase_s && vis_sel_s;
        rgb_d     = visible_d ? rgb_sel_s : {RGB_W{1'b0}};
    end

    // FSM and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= {GW{1'b0}};
            visible_q <= 1'b0;
            rgb_q     <= {RGB_W{1'b0}};
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            visible_q <= visible_d;
            rgb_q     <= rgb_d;
        end
    end

    assign visible = visible_q;
    assign rgb     = rgb_q;
    assign active  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_result_overlay_mux.sv
// Randomised and directed bench for result_overlay_mux with a queue-based
// scoreboard fed by an abstract model of the banner behaviour.
module tb_result_overlay_mux;

    localparam int N_SRC = 3;
    localparam int RGB_W = 24;
    localparam int P     = 2;
    localparam int T     = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   frame_tick;
    logic                   gano;
    logic                   empate;
    logic [1:0]             ganador;
    logic                   clear;
    logic [N_SRC-1:0]       src_visible;
    logic [N_SRC*RGB_W-1:0] src_rgb;
    logic                   visible;
    logic [RGB_W-1:0]       rgb;
    logic                   active;

    typedef struct packed {
        logic             act;
        logic             vis;
        logic [RGB_W-1:0] rgb;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_x;
    int   errors = 0;
    int   checks = 0;

    // Abstract model: banner on/off, chosen source, frame ticks since latch.
    bit   m_active = 1'b0;
    int   m_sel    = 0;
    int   m_ticks  = 0;
    bit   rand_src = 1'b0;

    result_overlay_mux #(
        .N_SRC         (N_SRC),
        .RGB_W         (RGB_W),
        .BLINK_PERIOD  (P),
        .BLINK_TOGGLES (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .gano        (gano),
        .empate      (empate),
        .ganador     (ganador),
        .clear       (clear),
        .src_visible (src_visible),
        .src_rgb     (src_rgb),
        .visible     (visible),
        .rgb         (rgb),
        .active      (active)
    );

    always #5 clk = ~clk;

    function automatic bit m_phase();
        return (m_ticks >= P*T) || (((m_ticks / P) % 2) == 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit tk, input bit g, input bit e, input int gn, input bit cl);
        exp_t x;
        bit   valid;
        int   vsel;
        @(negedge clk);
        frame_tick = tk;
        gano       = g;
        empate     = e;
        ganador    = 2'(gn);
        clear      = cl;
        if (rand_src) begin
            src_visible = 3'($urandom_range(7, 0));
            for (int i = 0; i < N_SRC; i++) src_rgb[i*RGB_W +: RGB_W] = 24'($urandom);
        end else begin
            src_visible = 3'b111;
            src_rgb     = {24'h00FF00, 24'h0000FF, 24'hFF0000};
        end
        x.vis = m_active && m_phase() && src_visible[m_sel];
        x.rgb = x.vis ? src_rgb[m_sel*RGB_W +: RGB_W] : 24'h000000;
        valid = 1'b0;
        vsel  = 0;
        if (cl) begin
            m_active = 1'b0;
            m_ticks  = 0;
        end else if (!m_active) begin
            if (tk && e) begin
                valid = 1'b1;
                vsel  = N_SRC - 1;
            end else if (tk && g && gn >= 1 && gn <= N_SRC - 1) begin
                valid = 1'b1;
                vsel  = gn - 1;
            end
            if (valid) begin
                m_active = 1'b1;
                m_sel    = vsel;
                m_ticks  = 0;
            end
        end else if (tk && m_ticks < P*T) begin
            m_ticks++;
        end
        x.act = m_active;
        sb_q.push_back(x);
    endtask

    task automatic idle_inputs();
        frame_tick = 1'b0;
        gano       = 1'b0;
        empate     = 1'b0;
        ganador    = 2'd0;
        clear      = 1'b0;
    endtask

    // Asynchronous reset in the middle of a low clock phase.
    task automatic mid_reset();
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        check("async_rst_visible", visible, 0);
        check("async_rst_rgb", rgb, 0);
        check("async_rst_active", active, 0);
        m_active = 1'b0;
        m_ticks  = 0;
        m_sel    = 0;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compare each registered output against the queued expectation.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_x = sb_q.pop_front();
            check("active", active, mon_x.act);
            check("visible", visible, mon_x.vis);
            check("rgb", rgb, mon_x.rgb);
        end
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        src_visible = 3'b111;
        src_rgb     = {24'h00FF00, 24'h0000FF, 24'hFF0000};
        #1 rst = 1'b1;
        #1;
        check("reset_visible", visible, 0);
        check("reset_rgb", rgb, 0);
        check("reset_active", active, 0);
        @(negedge clk);
        rst = 1'b0;

        // Winner 1, then keep offering winner 2 while blinking.
        drive(1, 1, 0, 1, 0);
        for (int i = 0; i < 26; i++) drive((i % 3) == 2, 1, 0, 2, 0);

        // Clear colliding with a tick and a valid result, then a late relatch.
        drive(1, 1, 0, 2, 1);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 2, 0);
        drive(1, 1, 0, 2, 0);
        for (int i = 0; i < 6; i++) drive((i % 2) == 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);

        // Invalid winner codes never start the banner.
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);
        drive(1, 1, 0, 3, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0);

        // Draw outranks a simultaneous winner.
        drive(1, 1, 1, 2, 0);
        for (int i = 0; i < 10; i++) drive((i % 2) == 0, 0, 0, 0, 0);

        // Reset mid-blink drops the result; the next tick samples afresh.
        mid_reset();
        drive(0, 1, 0, 1, 0);
        drive(1, 1, 0, 2, 0);
        for (int i = 0; i < 5; i++) drive(i == 2, 0, 0, 0, 0);

        rand_src = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(2, 0) == 0, $urandom_range(1, 0) == 1,
                  $urandom_range(7, 0) == 0, int'($urandom_range(3, 0)),
                  $urandom_range(39, 0) == 0);
        end
        for (int i = 0; i < 4; i++) mid_reset();

        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #3;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
